// File: rtl/aes128_mode_engine.sv
// AES-128 ECB/CBC/CTR block engine with an iterative core and output FIFO.
// Define AES_MODE_CTR_EN to build CTR mode; otherwise mode 10 is illegal.
module aes128_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_key_i,
  input  logic [127:0] key_i,
  input  logic         start_enc_i,
  input  logic         start_dec_i,
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [127:0] data_o
);
  typedef enum logic [1:0] {C_IDLE, C_KEY, C_RUN} cst_t;
  cst_t         cst_q;
  logic         dec_q, done_q;
  logic [3:0]   rnd_q;
  logic [7:0]   rcon_q;
  logic [127:0] rk_q, key0_q, keyl_q, st_q;
  logic [127:0] rk_e, rk_d, enc_sr, dec_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] ixt(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  // a^254 is the field inverse (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, x;
    r = 8'h01; x = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gm(r, x);
      x = gm(x, x);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b,1) ^ rl(b,2) ^ rl(b,3) ^ rl(b,4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] a);
    return ginv(rl(a,1) ^ rl(a,3) ^ rl(a,6) ^ 8'h05);
  endfunction
  function automatic logic [127:0] sub(input logic [127:0] s,
                                       input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv ? isb(s[127-8*k -: 8]) : sb(s[127-8*k -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] shr(input logic [127:0] s,
                                       input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s,
                                       input logic inv);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   cf [4];
    logic [7:0]   b;
    cf[0] = inv ? 8'h0e : 8'h02;
    cf[1] = inv ? 8'h0b : 8'h03;
    cf[2] = inv ? 8'h0d : 8'h01;
    cf[3] = inv ? 8'h09 : 8'h01;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*c+i) -: 8];
      for (int i = 0; i < 4; i++) begin
        b = '0;
        for (int j = 0; j < 4; j++) b = b ^ gm(a[(i+j)%4], cf[j]);
        o[127-8*(4*c+i) -: 8] = b;
      end
    end
    return o;
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction
  function automatic logic [127:0] nk(input logic [127:0] k,
                                      input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sw({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] pk(input logic [127:0] k,
                                      input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
    w0 = w0 ^ sw({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // One round of key schedule and cipher per cycle, both directions
  always_comb begin
    rk_e   = nk(rk_q, rcon_q);
    rk_d   = pk(rk_q, rcon_q);
    enc_sr = shr(sub(st_q, 1'b0), 1'b0);
    dec_t  = sub(shr(st_q, 1'b1), 1'b1) ^ rk_d;
  end

  // Key expansion to the last round key, then iterative rounds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst_q <= C_IDLE; dec_q <= 1'b0; done_q <= 1'b0;
      rnd_q <= '0; rcon_q <= '0; rk_q <= '0;
      key0_q <= '0; keyl_q <= '0; st_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (cst_q)
        C_IDLE: begin
          rnd_q <= '0;
          if (load_key_i) begin
            rk_q <= key_i; key0_q <= key_i;
            rcon_q <= 8'h01; cst_q <= C_KEY;
          end else if (start_enc_i || start_dec_i) begin
            dec_q  <= start_dec_i;
            st_q   <= data_i ^ (start_dec_i ? keyl_q : key0_q);
            rk_q   <= start_dec_i ? keyl_q : key0_q;
            rcon_q <= start_dec_i ? 8'h36 : 8'h01;
            cst_q  <= C_RUN;
          end
        end
        C_KEY: begin
          rk_q <= rk_e; rcon_q <= xt(rcon_q);
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd9) begin
            keyl_q <= rk_e; cst_q <= C_IDLE;
          end
        end
        C_RUN: begin
          if (!dec_q) begin
            rk_q <= rk_e; rcon_q <= xt(rcon_q);
            st_q <= ((rnd_q == 4'd9) ? enc_sr : mix(enc_sr, 1'b0)) ^ rk_e;
          end else begin
            rk_q <= rk_d; rcon_q <= ixt(rcon_q);
            st_q <= (rnd_q == 4'd9) ? dec_t : mix(dec_t, 1'b1);
          end
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd9) begin
            done_q <= 1'b1; cst_q <= C_IDLE;
          end
        end
        default: cst_q <= C_IDLE;
      endcase
    end
  end

  assign ready_o = (cst_q == C_IDLE);
  assign done_o  = done_q;
  assign data_o  = st_q;
endmodule

module aes128_mode_engine #(
  parameter int OBUF_DEPTH = 2,
  parameter int CTR_W      = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load_i,
  input  logic [127:0]     key_i,
  input  logic             iv_load_i,
  input  logic [127:0]     iv_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] blk_cnt_o
);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  if (OBUF_DEPTH < 1 || OBUF_DEPTH > 8 || CTR_W < 8 || CTR_W > 128)
  begin : g_bad_param
    $error("aes128_mode_engine: illegal OBUF_DEPTH or CTR_W");
  end

  typedef enum logic [2:0] {IDLE, KEY, START, WAIT, PUSH} state_t;
  state_t state_q, state_d;

  logic         core_ready, core_done, core_load, core_enc, core_dec;
  logic [127:0] core_out;
  logic         key_valid_q, err_q, dec_q, cbc_enc_q;
  logic [127:0] chain_q, core_in_q, xor_q, res_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic [127:0] mem_q [OBUF_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic         full, push, pop, acc, legal;
  logic         blk_dec, blk_cbc_enc;
  logic [127:0] chain_eff, blk_in, blk_xor, blk_chain;

  aes128_core u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_key_i  (core_load),
    .key_i       (key_i),
    .start_enc_i (core_enc),
    .start_dec_i (core_dec),
    .data_i      (core_in_q),
    .ready_o     (core_ready),
    .done_o      (core_done),
    .data_o      (core_out)
  );

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (cnt_q == CW'(OBUF_DEPTH));
  assign in_ready_o  = (state_q == IDLE) && key_valid_q && core_ready
                       && !full && !key_load_i;
  assign acc         = in_valid_i && in_ready_o;
  assign push        = (state_q == PUSH);
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;
  assign key_valid_o = key_valid_q;
  assign busy_o      = (state_q != IDLE) || out_valid_o;
  assign err_o       = err_q;
  assign blk_cnt_o   = blk_cnt_q;

  // Per-mode core input, output mask and next chain at accept
  always_comb begin
    chain_eff   = iv_load_i ? iv_i : chain_q;
    blk_in      = in_data_i;
    blk_xor     = '0;
    blk_chain   = chain_eff;
    blk_dec     = dir_i;
    blk_cbc_enc = 1'b0;
    legal       = 1'b0;
    case (mode_i)
      2'b00: legal = 1'b1;
      2'b01: begin
        legal = 1'b1;
        if (dir_i) begin
          blk_xor   = chain_eff;
          blk_chain = in_data_i;
        end else begin
          blk_in      = in_data_i ^ chain_eff;
          blk_cbc_enc = 1'b1;
        end
      end
`ifdef AES_MODE_CTR_EN
      2'b10: begin
        legal   = 1'b1;
        blk_in  = chain_eff;
        blk_xor = in_data_i;
        blk_dec = 1'b0;
        blk_chain[CTR_W-1:0] = chain_eff[CTR_W-1:0] + CTR_W'(1);
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and single-cycle core command pulses
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_enc  = 1'b0;
    core_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_load_i && core_ready) begin
          core_load = 1'b1;
          state_d   = KEY;
        end else if (acc && legal) begin
          state_d = START;
        end
      end
      KEY:   if (core_ready) state_d = IDLE;
      START: begin
        core_enc = core_ready && !dec_q;
        core_dec = core_ready && dec_q;
        state_d  = WAIT;
      end
      WAIT:  if (core_done) state_d = PUSH;
      PUSH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Chain, block context, result capture, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0; err_q <= 1'b0;
      dec_q <= 1'b0; cbc_enc_q <= 1'b0;
      chain_q <= '0; core_in_q <= '0;
      xor_q <= '0; res_q <= '0; blk_cnt_q <= '0;
    end else begin
      err_q <= acc && !legal;
      if (state_q == IDLE) begin
        if (acc && legal) chain_q <= blk_chain;
        else if (iv_load_i) chain_q <= iv_i;
      end
      if (acc && legal) begin
        core_in_q <= blk_in;
        xor_q     <= blk_xor;
        dec_q     <= blk_dec;
        cbc_enc_q <= blk_cbc_enc;
      end
      if (state_q == KEY && core_ready) key_valid_q <= 1'b1;
      if (state_q == WAIT && core_done) res_q <= core_out;
      if (push) begin
        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
        if (cbc_enc_q) chain_q <= res_q;
      end
    end
  end

  // Output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= res_q ^ xor_q;
        wptr_q <= inc(wptr_q);
      end
      if (pop) rptr_q <= inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: tb/tb_aes128_mode_engine.sv
// Directed bench for aes128_mode_engine using FIPS-197 / SP800-38A vectors.
// Each scenario task checks its own results inline.
module tb_aes128_mode_engine;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PX = PT ^ CT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load_i, iv_load_i, dir_i, in_valid_i, out_ready_i;
  logic [127:0] key_i, iv_i, in_data_i;
  logic [1:0]   mode_i;
  logic         in_ready_o, out_valid_o, key_valid_o, busy_o, err_o;
  logic [127:0] out_data_o;
  logic [15:0]  blk_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  aes128_mode_engine dut (
    .clk(clk), .rst_n(rst_n),
    .key_load_i(key_load_i), .key_i(key_i),
    .iv_load_i(iv_load_i), .iv_i(iv_i),
    .mode_i(mode_i), .dir_i(dir_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .key_valid_o(key_valid_o), .busy_o(busy_o),
    .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  task automatic load_key(input logic [127:0] k);
    bit ok;
    @(negedge clk);
    key_load_i = 1'b1; key_i = k;
    @(posedge clk); #1 key_load_i = 1'b0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL key_load_timeout busy=%b want 0", busy_o);
    end
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(negedge clk);
    iv_load_i = 1'b1; iv_i = v;
    @(posedge clk); #1 iv_load_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic d,
                      input logic [127:0] data,
                      input logic ivl, input logic [127:0] iv);
    bit ok;
    @(negedge clk);
    mode_i = m; dir_i = d; in_data_i = data;
    iv_load_i = ivl; iv_i = iv; in_valid_i = 1'b1;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (in_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0; iv_load_i = 1'b0;
  endtask

  task automatic recv(output logic [127:0] d);
    bit ok;
    ok = 0;
    d = 'x;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL recv_timeout out_valid=%b want 1", out_valid_o);
    end else begin
      d = out_data_o;
      out_ready_i = 1'b1;
      @(posedge clk); #1 out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_load_i = 0; iv_load_i = 0; dir_i = 0; in_valid_i = 1;
    out_ready_i = 0; key_i = '0; iv_i = '0; in_data_i = '0;
    mode_i = 2'b00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid_o !== 1'b0 || out_data_o !== 128'h0) begin
      n_bad++;
      $display("FAIL rst_out got v=%b d=%h want 0/0",
               out_valid_o, out_data_o);
    end
    n_cmp++;
    if ({in_ready_o, busy_o, err_o, key_valid_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_flags got %b%b%b%b want 0000",
               in_ready_o, busy_o, err_o, key_valid_o);
    end
    n_cmp++;
    if (blk_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_cnt got %0d want 0", blk_cnt_o);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL nokey_ready got %b want 0", in_ready_o);
    end
    in_valid_i = 0;
  endtask

  task automatic test_ecb();
    logic [127:0] d;
    load_key(K1);
    n_cmp++;
    if (key_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL key_valid got %b want 1", key_valid_o);
    end
    send(2'b00, 1'b0, PT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL ecb_enc got %h want %h", d, CT);
    end
    n_cmp++;
    if (blk_cnt_o !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL ecb_cnt got %0d want %0d", blk_cnt_o, exp_cnt);
    end
    send(2'b00, 1'b1, CT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== PT) begin
      n_bad++;
      $display("FAIL ecb_dec got %h want %h", d, PT);
    end
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy got %b want 0", busy_o);
    end
  endtask

  task automatic test_key_reload();
    logic [127:0] d;
    load_key(K2);
    send(2'b00, 1'b0, P2, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== C2) begin
      n_bad++;
      $display("FAIL k2_enc got %h want %h", d, C2);
    end
    send(2'b00, 1'b1, C2, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== P2) begin
      n_bad++;
      $display("FAIL k2_dec got %h want %h", d, P2);
    end
    load_key(K1);
  endtask

  task automatic test_cbc();
    logic [127:0] d;
    load_iv('0);
    send(2'b01, 1'b0, PT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL cbc_enc1 got %h want %h", d, CT);
    end
    send(2'b01, 1'b0, PX, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL cbc_enc2 got %h want %h", d, CT);
    end
    load_iv('0);
    send(2'b01, 1'b1, CT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== PT) begin
      n_bad++;
      $display("FAIL cbc_dec1 got %h want %h", d, PT);
    end
    send(2'b01, 1'b1, CT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== PX) begin
      n_bad++;
      $display("FAIL cbc_dec2 got %h want %h", d, PX);
    end
  endtask

  task automatic test_iv_same_cycle();
    logic [127:0] d;
    logic [127:0] iv;
    iv = 128'hdeadbeef0123456789abcdeffedcba98;
    send(2'b01, 1'b0, PT ^ iv, 1'b1, iv); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL iv_same_cycle got %h want %h", d, CT);
    end
  endtask

  task automatic test_illegal(input logic [1:0] m);
    int c0;
    c0 = exp_cnt;
    send(m, 1'b0, PT, 1'b0, '0);
    @(negedge clk);
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_pulse m=%b got %b want 1", m, err_o);
    end
    @(negedge clk);
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_width m=%b got %b want 0", m, err_o);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (out_valid_o !== 1'b0 || blk_cnt_o !== 16'(c0)) begin
      n_bad++;
      $display("FAIL err_noout m=%b got v=%b cnt=%0d want 0/%0d",
               m, out_valid_o, blk_cnt_o, c0);
    end
  endtask

`ifdef AES_MODE_CTR_EN
  task automatic test_ctr();
    logic [127:0] d;
    load_iv(PT);
    send(2'b10, 1'b0, '0, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL ctr_enc got %h want %h", d, CT);
    end
    n_cmp++;
    if (dut.chain_q !== 128'h00112233445566778899aabbccddef00) begin
      n_bad++;
      $display("FAIL ctr_inc got %h want %h", dut.chain_q,
               128'h00112233445566778899aabbccddef00);
    end
    load_iv(PT);
    send(2'b10, 1'b1, CT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== 128'h0) begin
      n_bad++;
      $display("FAIL ctr_dec got %h want 0", d);
    end
    load_iv(128'h00112233445566778899ccddffffffff);
    send(2'b10, 1'b0, PT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (dut.chain_q !== 128'h00112233445566778899ccdd00000000) begin
      n_bad++;
      $display("FAIL ctr_wrap got %h want %h", dut.chain_q,
               128'h00112233445566778899ccdd00000000);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [127:0] d;
    bit stalled, ok;
    out_ready_i = 1'b0;
    send(2'b00, 1'b0, PT, 1'b0, '0); exp_cnt++;
    send(2'b00, 1'b1, CT, 1'b0, '0); exp_cnt++;
    @(negedge clk);
    mode_i = 2'b00; dir_i = 1'b0; in_data_i = PT; in_valid_i = 1'b1;
    stalled = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready_o) stalled = 0;
    end
    n_cmp++;
    if (!stalled) begin
      n_bad++;
      $display("FAIL full_stall in_ready got 1 want 0");
    end
    n_cmp++;
    if (out_valid_o !== 1'b1 || blk_cnt_o !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL full_state got v=%b cnt=%0d want 1/%0d",
               out_valid_o, blk_cnt_o, exp_cnt);
    end
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL order1 got %h want %h", d, CT);
    end
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL resume_timeout in_ready=%b want 1", in_ready_o);
    end
    @(posedge clk); #1 in_valid_i = 1'b0;
    exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== PT) begin
      n_bad++;
      $display("FAIL order2 got %h want %h", d, PT);
    end
    recv(d);
    n_cmp++;
    if (d !== CT) begin
      n_bad++;
      $display("FAIL order3 got %h want %h", d, CT);
    end
    n_cmp++;
    if (blk_cnt_o !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL b2b_cnt got %0d want %0d", blk_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d;
    bit stuck;
    out_ready_i = 1'b0;
    send(2'b00, 1'b0, PT, 1'b0, '0);
    send(2'b00, 1'b0, PT, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid_o, busy_o, err_o, key_valid_o, in_ready_o} !== 5'b0
        || out_data_o !== 128'h0 || blk_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL midrst got v=%b b=%b e=%b k=%b r=%b d=%h c=%0d want 0s",
               out_valid_o, busy_o, err_o, key_valid_o, in_ready_o,
               out_data_o, blk_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    in_valid_i = 1'b1;
    stuck = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready_o || key_valid_o || out_valid_o) stuck = 0;
    end
    in_valid_i = 1'b0;
    n_cmp++;
    if (!stuck) begin
      n_bad++;
      $display("FAIL postrst_nokey got ready/kv/ov activity want none");
    end
    load_key(K1);
    send(2'b00, 1'b0, PT, 1'b0, '0); exp_cnt++;
    recv(d);
    n_cmp++;
    if (d !== CT || blk_cnt_o !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL postrst_ecb got %h cnt=%0d want %h cnt=%0d",
               d, blk_cnt_o, CT, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ecb();
    test_key_reload();
    test_cbc();
    test_iv_same_cycle();
`ifdef AES_MODE_CTR_EN
    test_ctr();
`else
    test_illegal(2'b10);
`endif
    test_illegal(2'b11);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes128_mode_engine.md
AES128_MODE_ENGINE -- requirements
Module: aes128_mode_engine

Interface
REQ-001 SHALL have parameter OBUF_DEPTH, default 2: output buffer depth in 128-bit blocks, legal values 1..8.
REQ-002 SHALL have parameter CTR_W, default 32: width of the CTR-mode increment field, legal values 8..128.
REQ-003 SHALL have parameter CNT_W, default 16: width of the processed-block counter.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port key_load_i  in  1  load-key request; key is taken from key_i.
REQ-007 SHALL have port key_i  in  128  AES-128 key.
REQ-008 SHALL have port iv_load_i  in  1  IV/counter load request; value is taken from iv_i.
REQ-009 SHALL have port iv_i  in  128  IV (CBC) or initial counter block (CTR).
REQ-010 SHALL have port mode_i  in  2  mode select: 00 ECB, 01 CBC, 10 CTR, 11 illegal; sampled at block accept.
REQ-011 SHALL have port dir_i  in  1  direction: 0 encrypt, 1 decrypt; sampled at block accept.
REQ-012 SHALL have ports in_valid_i (in, 1), in_ready_o (out, 1) and in_data_i (in, 128) forming the input block handshake.
REQ-013 SHALL have ports out_valid_o (out, 1), out_ready_i (in, 1) and out_data_o (out, 128) forming the output block handshake.
REQ-014 SHALL have ports key_valid_o (out, 1), busy_o (out, 1), err_o (out, 1) and blk_cnt_o (out, CNT_W).

Function
REQ-015 SHALL instantiate one aes128_core and drive its load_key_i/start_enc_i/start_dec_i as single-cycle pulses, only while its ready_o is high.
REQ-016 SHALL implement FSM states IDLE, KEY, START, WAIT and PUSH.
- IDLE->KEY on key_load_i.
- IDLE->START on an accepted block.
- KEY->IDLE when core ready_o returns high.
- START->WAIT after the start pulse.
- WAIT->PUSH when core done_o is sampled high; core data_o is captured on that edge.
- PUSH->IDLE after writing the output buffer.
REQ-017 SHALL assert in_ready_o only in IDLE with key_valid_o=1, core ready_o=1, output buffer not full and key_load_i=0; a block is accepted when in_valid_i and in_ready_o are both high.
REQ-018 SHALL give key_load_i priority over a simultaneous in_valid_i, and SHALL ignore key_load_i or iv_load_i outside IDLE.
REQ-019 SHALL set key_valid_o on leaving KEY, and keep it set until reset.
REQ-020 In IDLE, iv_load_i SHALL write iv_i into the 128-bit chain register in one cycle; a simultaneous block accept uses the new value.
REQ-021 ECB: core input = in_data_i; core op = dir_i; output = core result.
REQ-022 CBC encrypt: core input = in_data_i XOR chain; output = result; chain <= result.
REQ-023 CBC decrypt: core input = in_data_i; output = result XOR chain; chain <= in_data_i as captured at accept.
REQ-024 CTR, both directions: core input = chain with core op encrypt; output = in_data_i XOR result.
- chain[CTR_W-1:0] increments by 1 modulo 2^CTR_W.
- The upper chain bits never change.
REQ-025 The output buffer SHALL be a FIFO of OBUF_DEPTH entries.
- out_valid_o = not empty; out_data_o = head entry.
- An entry is popped on out_valid_o and out_ready_i both high.
- A push and a pop in the same cycle keep the occupancy unchanged.
REQ-026 mode_i=11 (or 10 when CTR is compiled out) SHALL consume the block, produce no output, leave the chain unchanged, and pulse err_o for exactly one cycle.
REQ-027 blk_cnt_o SHALL increment by 1 per buffer push and wrap to 0 after 2^CNT_W-1.
REQ-028 busy_o SHALL be high in every state except IDLE, and also while the buffer is non-empty.

Reset
REQ-029 rst_n low SHALL immediately force: FSM=IDLE, key_valid_o=0, chain=0, buffer empty, out_valid_o=0, out_data_o=0, in_ready_o=0, busy_o=0, err_o=0, blk_cnt_o=0.
REQ-030 Reset mid-operation SHALL discard any in-flight block and all buffered blocks; a key load is required again afterwards.

Configuration
REQ-031 With macro AES_MODE_CTR_EN defined, CTR mode SHALL operate as specified in REQ-024; without it, the CTR increment logic SHALL be absent and mode 10 SHALL be treated as illegal per REQ-026.

Verification
REQ-032 ECB encrypt: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> out_data_o 69c4e0d86a7b0430d8cdb78070b4c55a, blk_cnt_o=1.
REQ-033 CBC with IV 0: encrypt the same plaintext -> 69c4e0d86a7b0430d8cdb78070b4c55a; reload IV 0, decrypt that ciphertext -> 00112233445566778899aabbccddeeff.
REQ-034 CTR (AES_MODE_CTR_EN defined): IV 00112233445566778899aabbccddeeff, in_data 0 -> 69c4e0d86a7b0430d8cdb78070b4c55a; IV ...ccddffffffff -> chain becomes ...ccdd00000000 with the upper bits unchanged.
REQ-035 out_ready_i held 0, OBUF_DEPTH=2: stream 3 ECB blocks -> two outputs buffered, in_ready_o stays 0; on release, outputs appear in order.
REQ-036 mode_i=11 block -> err_o single-cycle pulse, no out_valid_o, blk_cnt_o unchanged; mode 10 without the macro gives the same response.
REQ-037 rst_n pulsed low during WAIT -> all outputs at reset values, key_valid_o=0, in_ready_o=0 until a new key load completes.
